// File: rtl/axis_iq_decimator.sv
// axis_iq_decimator: AXI-Stream dual-lane I/Q boxcar decimator by 2^DECIM_LOG2 with frame-marked output
module axis_iq_decimator #(
  parameter int DECIM_LOG2 = 2,
  parameter int FRAME_LEN  = 256
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [3:0]  s_axis_tstrb,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [3:0]  m_axis_tstrb,
  output logic        m_axis_tlast,
  input  logic        enable
);
  localparam int AW = 16 + DECIM_LOG2;
  localparam int FW = $clog2(FRAME_LEN);
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, sum_a, sum_b;
  logic [FW-1:0] frame_q, frame_d, frame_nxt;
  logic [31:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  logic accept, nth, out_hs, unused_in;
  assign unused_in = ^{s_axis_tstrb, s_axis_tlast};
  assign s_axis_tready = !s_axis_areset && !(enable && (&cnt_q) && valid_q && !m_axis_tready);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign nth = enable && accept && (&cnt_q);
  assign out_hs = valid_q && m_axis_tready;
  // N samples of 16 bits always fit in 16+DECIM_LOG2 bits, so the sum cannot overflow
  assign sum_a = acc_a_q + {{DECIM_LOG2{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
  assign sum_b = acc_b_q + {{DECIM_LOG2{s_axis_tdata[31]}}, s_axis_tdata[31:16]};
  assign frame_nxt = (frame_q == FW'(FRAME_LEN - 1)) ? '0 : frame_q + FW'(1);
  always_comb begin
    acc_a_d = (!enable || nth) ? '0 : accept ? sum_a : acc_a_q;
    acc_b_d = (!enable || nth) ? '0 : accept ? sum_b : acc_b_q;
    cnt_d   = !enable ? '0 : accept ? cnt_q + DECIM_LOG2'(1) : cnt_q;
    frame_d = out_hs ? frame_nxt : frame_q;
    valid_d = nth || (valid_q && !m_axis_tready);
    data_d  = nth ? {sum_b[AW-1:DECIM_LOG2], sum_a[AW-1:DECIM_LOG2]} : data_q;
    // a result loading alongside a handshake belongs to the following frame slot
    last_d  = nth ? ((out_hs ? frame_nxt : frame_q) == FW'(FRAME_LEN - 1)) : last_q;
  end
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      cnt_q   <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      frame_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tstrb  = 4'hF;
endmodule

// File: tb/tb_axis_iq_decimator.sv
// tb_axis_iq_decimator: directed checks of decimation, backpressure, framing, reset and enable flush
module tb_axis_iq_decimator;
  logic clk = 1'b0, rst = 1'b1, s_tvalid = 1'b0, s_tready, m_tvalid, m_tready = 1'b1, m_tlast, enable = 1'b1;
  logic s_tlast = 1'b0;
  logic [3:0] s_tstrb = 4'hF, m_tstrb;
  logic [31:0] s_tdata = '0, m_tdata;
  int n_cmp = 0, n_err = 0, ocnt = 0;
  always #5 clk = ~clk;
  axis_iq_decimator #(.DECIM_LOG2(2), .FRAME_LEN(4)) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tstrb(m_tstrb), .m_axis_tlast(m_tlast),
    .enable(enable));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic beats(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata = d;
      step();
    end
    s_tvalid = 1'b0;
  endtask
  // streams with m_tready=1; every output is compared and tlast must mark each 4th output
  task automatic stream(input int n, input logic [31:0] d, input logic [31:0] exp);
    for (int i = 0; i <= n; i++) begin
      s_tvalid = (i < n);
      s_tdata = d;
      step();
      if (m_tvalid) begin
        ocnt++;
        chk("stream_data", m_tdata, exp);
        chk("stream_tlast", {31'd0, m_tlast}, {31'd0, (ocnt % 4) == 0});
      end
    end
    s_tvalid = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    chk("m_tstrb", {28'd0, m_tstrb}, 32'hF);
    rst = 1'b0;
    #1;
    chk("post_rst_s_tready", {31'd0, s_tready}, 32'd1);
    // A 1,2,3,4 / B -1,-1,-1,-2 -> A=2, B=-2
    beats(1, 32'hFFFF_0001);
    beats(1, 32'hFFFF_0002);
    beats(1, 32'hFFFF_0003);
    chk("avg_not_yet", {31'd0, m_tvalid}, 32'd0);
    beats(1, 32'hFFFE_0004);
    chk("avg_valid", {31'd0, m_tvalid}, 32'd1);
    chk("avg_data", m_tdata, 32'hFFFE_0002);
    chk("avg_tlast", {31'd0, m_tlast}, 32'd0);
    step();
    chk("avg_cleared", {31'd0, m_tvalid}, 32'd0);
    // full-scale extremes must not wrap
    beats(4, 32'h7FFF_8000);
    chk("ext_valid", {31'd0, m_tvalid}, 32'd1);
    chk("ext_data", m_tdata, 32'h7FFF_8000);
    step();
    // backpressure: one pending result, three more beats, then the fourth must stall
    m_tready = 1'b0;
    beats(4, 32'h0004_0004);
    chk("bp_pending_data", m_tdata, 32'h0004_0004);
    chk("bp_pending_tlast", {31'd0, m_tlast}, 32'd0);
    beats(3, 32'h0008_0008);
    s_tvalid = 1'b1;
    s_tdata = 32'h000C_000C;
    #1;
    chk("bp_s_tready_low", {31'd0, s_tready}, 32'd0);
    step();
    step();
    chk("bp_still_low", {31'd0, s_tready}, 32'd0);
    chk("bp_hold_data", m_tdata, 32'h0004_0004);
    chk("bp_hold_valid", {31'd0, m_tvalid}, 32'd1);
    m_tready = 1'b1;
    #1;
    chk("bp_s_tready_high", {31'd0, s_tready}, 32'd1);
    step();
    s_tvalid = 1'b0;
    chk("bp_new_valid", {31'd0, m_tvalid}, 32'd1);
    chk("bp_new_data", m_tdata, 32'h0009_0009);
    chk("bp_new_tlast", {31'd0, m_tlast}, 32'd1);
    step();
    chk("bp_drained", {31'd0, m_tvalid}, 32'd0);
    // continuous outputs 5..12, tlast on 8 and 12
    ocnt = 4;
    stream(32, 32'h0001_0001, 32'h0001_0001);
    chk("cont_out_count", ocnt, 32'd12);
    // reset mid-accumulation discards partial sum and restarts frame
    beats(2, 32'h0064_0064);
    rst = 1'b1;
    step();
    chk("mid_rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    rst = 1'b0;
    ocnt = 0;
    stream(4, 32'h0008_0008, 32'h0008_0008);
    stream(12, 32'h0001_0001, 32'h0001_0001);
    chk("rst_out_count", ocnt, 32'd4);
    // enable low mid-accumulation flushes and discards
    beats(2, 32'h0002_0002);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata = 32'h7FFF_7FFF;
      #1;
      chk("dis_s_tready", {31'd0, s_tready}, 32'd1);
      step();
      chk("dis_no_output", {31'd0, m_tvalid}, 32'd0);
    end
    s_tvalid = 1'b0;
    enable = 1'b1;
    stream(4, 32'h0004_0004, 32'h0004_0004);
    chk("en_out_count", ocnt, 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axis_iq_decimator.md
AXIS_IQ_DECIMATOR -- requirements
Module: axis_iq_decimator

Interface
REQ-001 The block SHALL have parameter DECIM_LOG2, default 2, setting decimation factor N = 2^DECIM_LOG2 (legal 1..6).
REQ-002 The block SHALL have parameter FRAME_LEN, default 256, giving output beats per frame (legal 2..65536).
REQ-003 Port s_axis_aclk, input, 1 bit: single clock for all logic.
REQ-004 Port s_axis_areset, input, 1 bit: reset, synchronous to s_axis_aclk, active-high.
REQ-005 Port s_axis_tdata, input, 32 bits: ADC word; [15:0] = channel A, [31:16] = channel B, both signed two's complement.
REQ-006 Port s_axis_tvalid, input, 1 bit: upstream beat valid.
REQ-007 Port s_axis_tready, output, 1 bit: block accepts beat.
REQ-008 Port s_axis_tstrb, input, 4 bits: ignored.
REQ-009 Port s_axis_tlast, input, 1 bit: ignored.
REQ-010 Port m_axis_tdata, output, 32 bits: decimated word, same lane layout as input.
REQ-011 Port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-012 Port m_axis_tready, input, 1 bit: downstream accepts beat.
REQ-013 Port m_axis_tstrb, output, 4 bits: constant 4'hF.
REQ-014 Port m_axis_tlast, output, 1 bit: marks last beat of a frame.
REQ-015 Port enable, input, 1 bit: 1 = decimate; 0 = flush and discard input.

Function
REQ-016 An input beat SHALL be accepted only in a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-017 Per channel, the block SHALL sum N accepted samples in a signed accumulator of width 16+DECIM_LOG2, which SHALL never overflow.
REQ-018 Sample counter SHALL run 0..N-1, increment per accepted beat, and wrap to 0 on the Nth beat.
REQ-019 On the Nth accepted beat, each lane result SHALL be (accumulator + current sample) arithmetically shifted right by DECIM_LOG2 (floor, no rounding), truncated to 16 bits, and loaded into the output register.
REQ-020 The accumulator SHALL restart from the sample of the next accepted beat, with no lost or duplicated samples.
REQ-021 m_axis_tvalid SHALL assert in the cycle after the Nth beat is accepted (latency 1 clock).
REQ-022 m_axis_tdata and m_axis_tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 m_axis_tvalid SHALL clear after an output handshake unless a new result loads in the same cycle.
REQ-024 s_axis_tready SHALL be 0 only when enable=1, sample counter = N-1, m_axis_tvalid=1 and m_axis_tready=0; it SHALL be 1 otherwise.
REQ-025 A simultaneous output handshake and Nth-beat accept SHALL load the new result with m_axis_tvalid held at 1, allowing full throughput of one output per N inputs.
REQ-026 Frame counter SHALL run 0..FRAME_LEN-1 and increment on each output handshake, wrapping to 0 after FRAME_LEN-1.
REQ-027 m_axis_tlast SHALL be 1 for the result whose frame index is FRAME_LEN-1.
REQ-028 While enable=0, the block SHALL hold s_axis_tready=1, discard input, and clear the accumulators and sample counter.
REQ-029 While enable=0, a pending output SHALL still complete its handshake, and the frame counter SHALL be preserved.
REQ-030 When enable rises, decimation SHALL start from sample count 0.

Reset
REQ-031 While s_axis_areset=1 at a clock edge, the block SHALL drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, accumulators=0, sample counter=0, frame counter=0.
REQ-032 During reset, s_axis_tready SHALL be 0.
REQ-033 Reset asserted mid-accumulation or mid-frame SHALL discard partial sums and any pending output.
REQ-034 The first beat accepted after reset SHALL be sample 0 of frame 0.

Verification
REQ-035 N=4, tready=1, A lane 1,2,3,4 and B lane -1,-1,-1,-2 -> one output 0xFFFE_0002 (A=2, B=-2), one clock after the 4th beat.
REQ-036 Four beats of 0x7FFF_8000 -> output 0x7FFF_8000; no overflow or wrap.
REQ-037 m_axis_tready=0 with output pending and 3 beats accumulated -> s_axis_tready=0 until m_axis_tready=1, then the 4th beat is accepted with no sample lost.
REQ-038 FRAME_LEN=4, continuous input -> m_axis_tlast=1 on outputs 4, 8 and 12 only.
REQ-039 Reset after 2 accepted beats, then 4 beats of 8 -> first output lane value is 8, frame index 0.
REQ-040 enable=0 for 3 beats mid-accumulation, then 4 beats of 4 -> input stays accepted, discarded beats have no effect, and the next output is 4.
